// File: rtl/proc_core_param.sv
// proc_core_param: parametrised multicycle core with register-file PC, imm/ld/st/slt/mvnz and halt
module proc_core_param #(
  parameter int DATA_W = 16,
  parameter int NREG = 8,
  parameter int IADDR_W = 8,
  parameter int DADDR_W = 16,
  localparam int RIDX_W = $clog2(NREG)
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               run,
  output logic [IADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0]  imem_rdata,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [DADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0]  dmem_wdata,
  input  logic [DATA_W-1:0]  dmem_rdata,
  input  logic               dmem_ack,
  input  logic [RIDX_W-1:0]  dbg_sel,
  output logic [DATA_W-1:0]  dbg_data,
  output logic               done,
  output logic               halted,
  output logic               illegal,
  output logic               zflag
);
  localparam int INSTR_W = 4 + 2 * RIDX_W;
  localparam logic [RIDX_W-1:0] PC = RIDX_W'(NREG - 1);
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, IMM, WB, MEM, HALT} state_t;
  state_t state;
  logic [DATA_W-1:0] regs [NREG];
  logic [INSTR_W-1:0] ir;
  logic [DATA_W-1:0] g, pc, xv, yv, alu;
  logic [3:0] op;
  logic [RIDX_W-1:0] rx, ry;
  assign op = ir[INSTR_W-1 -: 4];
  assign rx = ir[2*RIDX_W-1 -: RIDX_W];
  assign ry = ir[RIDX_W-1:0];
  assign pc = regs[PC];
  assign xv = regs[rx];
  assign yv = regs[ry];
  assign alu = op == 4'd2 ? xv + yv : op == 4'd3 ? xv - yv :
               {{(DATA_W-1){1'b0}}, $signed(xv) < $signed(yv)};
  assign imem_addr = pc[IADDR_W-1:0];
  // Memory-side outputs come straight from state/IR/registers, none of which move during MEM
  assign dmem_req = state == MEM;
  assign dmem_we = state == MEM && op == 4'd5;
  assign dmem_addr = yv[DADDR_W-1:0];
  assign dmem_wdata = xv;
  assign dbg_data = regs[dbg_sel];
  assign halted = state == HALT;
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      ir <= '0;
      g <= '0;
      zflag <= 1'b0;
      done <= 1'b0;
      illegal <= 1'b0;
      state <= FETCH;
    end else begin
      done <= 1'b0;
      illegal <= 1'b0;
      case (state)
        FETCH: if (run) begin
          regs[PC] <= pc + DATA_W'(1);
          state <= DECODE;
        end
        DECODE: begin
          ir <= imem_rdata[INSTR_W-1:0];
          state <= EXEC;
        end
        EXEC: case (op)
          4'd0, 4'd6: begin
            if (op == 4'd0 || !zflag) regs[rx] <= yv;
            done <= 1'b1;
            state <= FETCH;
          end
          4'd1: state <= IMM;
          4'd2, 4'd3, 4'd7: begin
            g <= alu;
            state <= WB;
          end
          4'd4, 4'd5: state <= MEM;
          4'd8: state <= HALT;
          default: begin
            illegal <= 1'b1;
            done <= 1'b1;
            state <= FETCH;
          end
        endcase
        // rX write is issued after the increment so a PC target overrides it
        IMM: begin
          regs[PC] <= pc + DATA_W'(1);
          regs[rx] <= imem_rdata;
          done <= 1'b1;
          state <= FETCH;
        end
        WB: begin
          regs[rx] <= g;
          zflag <= g == '0;
          done <= 1'b1;
          state <= FETCH;
        end
        MEM: if (dmem_ack) begin
          if (op == 4'd4) regs[rx] <= dmem_rdata;
          done <= 1'b1;
          state <= FETCH;
        end
        HALT: state <= HALT;
        default: state <= FETCH;
      endcase
    end
  end
endmodule

// File: tb/tb_proc_core_param.sv
// tb_proc_core_param: directed programs against proc_core_param with hand-computed results
module tb_proc_core_param;
  logic clock = 1'b0;
  logic resetn, run, dmem_req, dmem_we, dmem_ack, done, halted, illegal, zflag;
  logic [7:0] imem_addr;
  logic [15:0] imem_rdata, dmem_addr, dmem_wdata, dmem_rdata, dbg_data;
  logic [2:0] dbg_sel;
  logic [15:0] imem [256];
  logic [15:0] dmem [256];
  int checks = 0, errors = 0, done_cnt = 0, ill_cnt = 0, ack_delay = 0, wait_cnt = 0;
  int d0, i0, cyc, n;

  proc_core_param dut (
    .clock(clock), .resetn(resetn), .run(run), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .dbg_sel(dbg_sel), .dbg_data(dbg_data),
    .done(done), .halted(halted), .illegal(illegal), .zflag(zflag)
  );

  always #5 clock = ~clock;
  always @(posedge clock) imem_rdata <= imem[imem_addr];
  assign dmem_ack = dmem_req && wait_cnt == ack_delay;
  assign dmem_rdata = dmem[dmem_addr[7:0]];
  always @(posedge clock) begin
    wait_cnt <= dmem_req ? wait_cnt + 1 : 0;
    if (dmem_req && dmem_ack && dmem_we) dmem[dmem_addr[7:0]] <= dmem_wdata;
  end
  always @(negedge clock) begin
    if (done) done_cnt <= done_cnt + 1;
    if (illegal) ill_cnt <= ill_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reg(input string tag, input int idx, input logic [15:0] exp);
    dbg_sel = 3'(idx);
    #1;
    chk(tag, {16'h0, dbg_data}, {16'h0, exp});
  endtask

  function automatic logic [15:0] enc(input int op, input int rx, input int ry);
    return 16'((op << 6) | (rx << 3) | ry);
  endfunction

  task automatic clear_imem();
    for (int i = 0; i < 256; i++) imem[i] = 16'h0200;
  endtask

  task automatic start();
    resetn = 1'b0;
    run = 1'b0;
    @(negedge clock);
    @(negedge clock);
    d0 = done_cnt;
    i0 = ill_cnt;
    resetn = 1'b1;
    run = 1'b1;
  endtask

  task automatic run_to_halt(input string tag);
    cyc = 0;
    while (!halted && cyc < 300) begin
      @(posedge clock);
      #1;
      cyc++;
    end
    chk(tag, {31'h0, halted}, 32'h1);
  endtask

  task automatic wait_req(input string tag);
    n = 0;
    while (!dmem_req && n < 100) begin
      @(posedge clock);
      #1;
      n++;
    end
    chk(tag, {31'h0, dmem_req}, 32'h1);
  endtask

  initial begin
    resetn = 1'b0;
    run = 1'b0;
    dbg_sel = '0;
    clear_imem();
    for (int i = 0; i < 256; i++) dmem[i] = '0;
    #1;
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_req", {31'h0, dmem_req}, 32'h0);
    chk("rst_halted", {31'h0, halted}, 32'h0);
    chk("rst_zflag", {31'h0, zflag}, 32'h0);
    chk("rst_iaddr", {24'h0, imem_addr}, 32'h0);

    // mvi r0,#5; mvi r1,#3; add r0,r1; halt
    imem[0] = enc(1, 0, 0); imem[1] = 16'd5;
    imem[2] = enc(1, 1, 0); imem[3] = 16'd3;
    imem[4] = enc(2, 0, 1); imem[5] = enc(8, 0, 0);
    start();
    run_to_halt("t1_halt");
    chk("t1_cycles", cyc, 15);
    chk("t1_done", done_cnt - d0, 3);
    chk("t1_zflag", {31'h0, zflag}, 32'h0);
    chk_reg("t1_r0", 0, 16'd8);
    chk_reg("t1_r1", 1, 16'd3);
    run = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("t1_stay_halted", {31'h0, halted}, 32'h1);

    // mvi r2,#7; mvi r4,#9; mvnz r5,r4 (z=0 writes); sub r2,r2; mvnz r3,r4 (z=1 skips); halt
    clear_imem();
    imem[0] = enc(1, 2, 0); imem[1] = 16'd7;
    imem[2] = enc(1, 4, 0); imem[3] = 16'd9;
    imem[4] = enc(6, 5, 4); imem[5] = enc(3, 2, 2);
    imem[6] = enc(6, 3, 4); imem[7] = enc(8, 0, 0);
    start();
    run_to_halt("t2_halt");
    chk("t2_cycles", cyc, 21);
    chk("t2_done", done_cnt - d0, 5);
    chk("t2_zflag", {31'h0, zflag}, 32'h1);
    chk_reg("t2_r2", 2, 16'd0);
    chk_reg("t2_r3", 3, 16'd0);
    chk_reg("t2_r5", 5, 16'd9);

    // mvi r7,#0x10 jumps to a halt at 0x10
    clear_imem();
    imem[0] = enc(1, 7, 0); imem[1] = 16'h0010;
    start();
    #1;
    chk("t3_addr_fetch", {24'h0, imem_addr}, 32'h0);
    @(posedge clock); #1;
    chk("t3_addr_decode", {24'h0, imem_addr}, 32'h1);
    @(posedge clock); #1;
    chk("t3_addr_exec", {24'h0, imem_addr}, 32'h1);
    @(posedge clock); #1;
    @(posedge clock); #1;
    chk("t3_addr_jump", {24'h0, imem_addr}, 32'h10);
    run_to_halt("t3_halt");
    chk_reg("t3_pc", 7, 16'h0011);
    chk("t3_done", done_cnt - d0, 1);

    // st r0->[r1] with 2-cycle ack delay, then ld r4<-[r1]
    clear_imem();
    imem[0] = enc(1, 0, 0); imem[1] = 16'hBEEF;
    imem[2] = enc(1, 1, 0); imem[3] = 16'h0040;
    imem[4] = enc(5, 0, 1); imem[5] = enc(4, 4, 1);
    imem[6] = enc(8, 0, 0);
    ack_delay = 2;
    start();
    wait_req("t4_req_seen");
    n = 0;
    while (dmem_req && n < 20) begin
      chk("t4_st_addr", {16'h0, dmem_addr}, 32'h0040);
      chk("t4_st_we", {31'h0, dmem_we}, 32'h1);
      chk("t4_st_wdata", {16'h0, dmem_wdata}, 32'hBEEF);
      @(posedge clock); #1;
      n++;
    end
    chk("t4_req_cycles", n, 3);
    chk("t4_mem", {16'h0, dmem[8'h40]}, 32'hBEEF);
    wait_req("t4_ld_req");
    chk("t4_ld_we", {31'h0, dmem_we}, 32'h0);
    run_to_halt("t4_halt");
    chk_reg("t4_r4", 4, 16'hBEEF);

    // slt of -1 < 1, then 0xFFFF+1 wraps to 0
    clear_imem();
    imem[0] = enc(1, 0, 0); imem[1] = 16'hFFFF;
    imem[2] = enc(1, 1, 0); imem[3] = 16'h0001;
    imem[4] = enc(7, 0, 1);
    imem[5] = enc(1, 2, 0); imem[6] = 16'hFFFF;
    imem[7] = enc(1, 3, 0); imem[8] = 16'h0001;
    imem[9] = enc(2, 2, 3); imem[10] = enc(8, 0, 0);
    ack_delay = 0;
    start();
    run_to_halt("t5_halt");
    chk("t5_cycles", cyc, 27);
    chk_reg("t5_slt", 0, 16'd1);
    chk_reg("t5_add_wrap", 2, 16'd0);
    chk("t5_zflag", {31'h0, zflag}, 32'h1);

    // illegal opcode 12, then reset while stuck in MEM
    clear_imem();
    imem[0] = enc(1, 1, 0); imem[1] = 16'h1234;
    imem[2] = enc(12, 1, 2); imem[3] = enc(4, 5, 1);
    ack_delay = 1000;
    start();
    wait_req("t6_req");
    chk("t6_illegal", ill_cnt - i0, 1);
    chk("t6_done", done_cnt - d0, 2);
    chk_reg("t6_r1", 1, 16'h1234);
    chk_reg("t6_r2", 2, 16'h0000);
    resetn = 1'b0;
    #1;
    chk("t6_req_async", {31'h0, dmem_req}, 32'h0);
    @(negedge clock);
    run = 1'b0;
    resetn = 1'b1;
    chk_reg("t6_pc", 7, 16'h0000);
    chk("t6_iaddr", {24'h0, imem_addr}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
